// File: rtl/wash_phase_sequencer_if.sv
// Signal bundle between the washing-machine sequencer and its environment.
// The slave side is the sequencer; the master side drives sensors and the tick.
interface wash_phase_sequencer_if;
  logic       tick;
  logic       start;
  logic       cancel;
  logic       lid_closed;
  logic       water_full;
  logic [2:0] state;
  logic [7:0] sec_left;
  logic       water_valve;
  logic       motor_wash;
  logic       motor_spin;
  logic       drain_valve;
  logic       door_lock;
  logic       paused;
  logic       done;
  logic       fault;

  modport master (
    output tick, start, cancel, lid_closed, water_full,
    input  state, sec_left, water_valve, motor_wash, motor_spin,
           drain_valve, door_lock, paused, done, fault
  );

  modport slave (
    input  tick, start, cancel, lid_closed, water_full,
    output state, sec_left, water_valve, motor_wash, motor_spin,
           drain_valve, door_lock, paused, done, fault
  );
endinterface

// File: rtl/wash_phase_sequencer.sv
// Fill/wash/rinse/spin cycle controller timed by a one-clk 1 Hz enable.
// Outputs are registered decodes of the next state, so they line up with state.
module wash_phase_sequencer #(
  parameter int unsigned FILL_SEC  = 10,
  parameter int unsigned WASH_SEC  = 20,
  parameter int unsigned RINSE_SEC = 15,
  parameter int unsigned SPIN_SEC  = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  wash_phase_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    WASH  = 3'd2,
    RINSE = 3'd3,
    SPIN  = 3'd4,
    DONE  = 3'd5,
    FAULT = 3'd6
  } state_t;

  state_t     st, st_n;
  logic [7:0] sec_n;
  logic       lid_q;
  logic       hold;
  logic       expire;
  logic       active_n;
  logic       pause_n;

  function automatic logic is_active(input state_t s);
    return (s == FILL) || (s == WASH) || (s == RINSE) || (s == SPIN);
  endfunction

  always_comb begin
    st_n   = st;
    sec_n  = bus.sec_left;
    hold   = is_active(st) && !lid_q;
    expire = bus.tick && (bus.sec_left == 8'd1);
    if (bus.cancel && st != DONE) begin
      st_n  = IDLE;
      sec_n = '0;
    end else if (!hold) begin
      case (st)
        IDLE: if (bus.start && lid_q) begin
          st_n  = FILL;
          sec_n = 8'(FILL_SEC);
        end
        // water_full wins over a coincident timeout
        FILL: if (bus.water_full) begin
          st_n  = WASH;
          sec_n = 8'(WASH_SEC);
        end else if (expire) begin
          st_n  = FAULT;
          sec_n = '0;
        end else if (bus.tick) begin
          sec_n = bus.sec_left - 8'd1;
        end
        WASH: if (expire) begin
          st_n  = RINSE;
          sec_n = 8'(RINSE_SEC);
        end else if (bus.tick) begin
          sec_n = bus.sec_left - 8'd1;
        end
        RINSE: if (expire) begin
          st_n  = SPIN;
          sec_n = 8'(SPIN_SEC);
        end else if (bus.tick) begin
          sec_n = bus.sec_left - 8'd1;
        end
        SPIN: if (expire) begin
          st_n  = DONE;
          sec_n = '0;
        end else if (bus.tick) begin
          sec_n = bus.sec_left - 8'd1;
        end
        DONE: begin
          st_n  = IDLE;
          sec_n = '0;
        end
        default: ;
      endcase
    end
    active_n = is_active(st_n);
    pause_n  = active_n && !lid_q;
  end

  // paused uses the pre-edge lid_q, giving the two-clk lid-to-paused delay
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st              <= IDLE;
      lid_q           <= 1'b0;
      bus.sec_left    <= '0;
      bus.water_valve <= 1'b0;
      bus.motor_wash  <= 1'b0;
      bus.motor_spin  <= 1'b0;
      bus.drain_valve <= 1'b0;
      bus.door_lock   <= 1'b0;
      bus.paused      <= 1'b0;
      bus.done        <= 1'b0;
      bus.fault       <= 1'b0;
    end else begin
      st              <= st_n;
      lid_q           <= bus.lid_closed;
      bus.sec_left    <= sec_n;
      bus.water_valve <= (st_n == FILL) && !pause_n;
      bus.motor_wash  <= ((st_n == WASH) || (st_n == RINSE)) && !pause_n;
      bus.motor_spin  <= (st_n == SPIN) && !pause_n;
      bus.drain_valve <= ((st_n == RINSE) || (st_n == SPIN)) && !pause_n;
      bus.door_lock   <= active_n;
      bus.paused      <= pause_n;
      bus.done        <= (st_n == DONE);
      bus.fault       <= (st_n == FAULT);
    end
  end

  assign bus.state = st;

endmodule

// File: tb/tb_wash_phase_sequencer.sv
// Randomized and directed bench for wash_phase_sequencer against a phase-table model.
module tb_wash_phase_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  wash_phase_sequencer_if bus();

  wash_phase_sequencer #(
    .FILL_SEC (3),
    .WASH_SEC (4),
    .RINSE_SEC(2),
    .SPIN_SEC (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Phase table: index = phase code; durations and actuator sets {valve, wash, spin, drain}
  int       dur[7]      = '{0, 3, 4, 2, 2, 0, 0};
  bit [3:0] act_mask[7] = '{4'b0000, 4'b1000, 4'b0100, 4'b0101, 4'b0011, 4'b0000, 4'b0000};

  int m_phase = 0;
  int m_sec   = 0;
  bit m_lidq  = 0;
  bit e_pa    = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0; m_sec = 0; m_lidq = 0; e_pa = 0;
    end else begin
      bit act;
      act = (m_phase >= 1 && m_phase <= 4);
      if (bus.cancel && m_phase != 5) begin
        m_phase = 0; m_sec = 0;
      end else if (act && !m_lidq) begin
        // frozen: nothing advances
      end else if (m_phase == 0) begin
        if (bus.start && m_lidq) begin m_phase = 1; m_sec = dur[1]; end
      end else if (m_phase == 5) begin
        m_phase = 0;
      end else if (m_phase == 1 && bus.water_full) begin
        m_phase = 2; m_sec = dur[2];
      end else if (act && bus.tick) begin
        if (m_sec > 1) m_sec--;
        else begin
          m_phase = (m_phase == 1) ? 6 : m_phase + 1;
          m_sec = dur[m_phase];
        end
      end
      e_pa   = (m_phase >= 1 && m_phase <= 4) && !m_lidq;
      m_lidq = bus.lid_closed;
    end
  end

  bit chk_on = 0;
  always @(negedge clk) begin
    if (chk_on) begin
      bit [3:0] mk;
      bit       ac;
      mk = e_pa ? 4'b0000 : act_mask[m_phase];
      ac = (m_phase >= 1 && m_phase <= 4);
      chk("state",       int'(bus.state),       m_phase);
      chk("sec_left",    int'(bus.sec_left),    m_sec);
      chk("water_valve", int'(bus.water_valve), int'(mk[3]));
      chk("motor_wash",  int'(bus.motor_wash),  int'(mk[2]));
      chk("motor_spin",  int'(bus.motor_spin),  int'(mk[1]));
      chk("drain_valve", int'(bus.drain_valve), int'(mk[0]));
      chk("door_lock",   int'(bus.door_lock),   int'(ac));
      chk("paused",      int'(bus.paused),      int'(e_pa));
      chk("done",        int'(bus.done),        int'(m_phase == 5));
      chk("fault",       int'(bus.fault),       int'(m_phase == 6));
    end
  end

  int tcnt     = 0;
  bit rand_tick = 0;
  int done_cnt = 0;
  int wash_eff = 0;

  task automatic cycle();
    logic [2:0] ps;
    logic [7:0] psec;
    logic       t;
    if (rand_tick) bus.tick = ($urandom_range(0, 3) == 0);
    else begin
      bus.tick = (tcnt == 4);
      tcnt = (tcnt + 1) % 5;
    end
    ps = bus.state; psec = bus.sec_left; t = bus.tick;
    @(posedge clk);
    @(negedge clk);
    if (bus.done) done_cnt++;
    if (t && ps == 3'd2 && (bus.state != 3'd2 || bus.sec_left != psec)) wash_eff++;
  endtask

  task automatic run_until(input int ph, input int budget, input string name);
    int n = 0;
    while (m_phase != ph && n < budget) begin cycle(); n++; end
    if (m_phase != ph) chk(name, int'(bus.state), ph);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1; cycle(); bus.start = 1'b0;
  endtask

  initial begin
    int seq_st[$];
    int seq_sec[$];
    bus.tick = 0; bus.start = 0; bus.cancel = 0; bus.lid_closed = 0; bus.water_full = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_state", int'(bus.state), 0);
    chk("reset_sec", int'(bus.sec_left), 0);
    chk("reset_lock", int'(bus.door_lock), 0);
    rst = 1'b0;
    chk_on = 1;

    // Full run
    bus.lid_closed = 1; cycle(); cycle();
    done_cnt = 0;
    pulse_start();
    chk("run_fill_state", int'(bus.state), 1);
    chk("run_fill_sec", int'(bus.sec_left), 3);
    chk("run_fill_valve", int'(bus.water_valve), 1);
    cycle(); cycle();
    bus.water_full = 1; cycle();
    chk("run_wash_state", int'(bus.state), 2);
    chk("run_wash_sec", int'(bus.sec_left), 4);
    chk("run_wash_motor", int'(bus.motor_wash), 1);
    for (int n = 0; n < 200 && bus.state != 3'd0; n++) begin
      logic [2:0] ps;
      ps = bus.state;
      cycle();
      if (bus.state != ps) begin seq_st.push_back(int'(bus.state)); seq_sec.push_back(int'(bus.sec_left)); end
    end
    bus.water_full = 0;
    chk("run_seq_len", seq_st.size(), 4);
    if (seq_st.size() == 4) begin
      chk("run_seq0", seq_st[0], 3); chk("run_sec0", seq_sec[0], 2);
      chk("run_seq1", seq_st[1], 4); chk("run_sec1", seq_sec[1], 2);
      chk("run_seq2", seq_st[2], 5);
      chk("run_seq3", seq_st[3], 0);
    end
    chk("run_done_cnt", done_cnt, 1);

    // Fill timeout
    pulse_start();
    run_until(6, 40, "timeout_wait");
    chk("to_state", int'(bus.state), 6);
    chk("to_fault", int'(bus.fault), 1);
    chk("to_valve", int'(bus.water_valve), 0);
    chk("to_lock", int'(bus.door_lock), 0);
    bus.cancel = 1; cycle(); bus.cancel = 0;
    chk("to_cancel_state", int'(bus.state), 0);
    chk("to_cancel_fault", int'(bus.fault), 0);

    // Pause mid-WASH at sec_left=3
    wash_eff = 0;
    bus.water_full = 1;
    pulse_start();
    for (int n = 0; n < 100 && !(m_phase == 2 && m_sec == 3); n++) cycle();
    bus.water_full = 0;
    bus.lid_closed = 0;
    repeat (16) cycle();
    chk("pause_flag", int'(bus.paused), 1);
    chk("pause_motor", int'(bus.motor_wash), 0);
    chk("pause_sec", int'(bus.sec_left), 3);
    chk("pause_lock", int'(bus.door_lock), 1);
    bus.lid_closed = 1;
    run_until(3, 100, "pause_resume_wait");
    chk("pause_wash_ticks", wash_eff, 4);
    bus.cancel = 1; cycle(); bus.cancel = 0;

    // Start gating
    bus.lid_closed = 0; cycle(); cycle();
    bus.start = 1; repeat (3) cycle(); bus.start = 0;
    chk("gate_lid", int'(bus.state), 0);
    bus.lid_closed = 1; cycle(); cycle();
    bus.start = 1; bus.cancel = 1; repeat (2) cycle(); bus.start = 0; bus.cancel = 0;
    chk("gate_cancel", int'(bus.state), 0);

    // Cancel mid-SPIN
    bus.water_full = 1;
    pulse_start();
    run_until(4, 150, "spin_wait");
    bus.water_full = 0;
    done_cnt = 0;
    bus.cancel = 1; cycle(); bus.cancel = 0;
    chk("cspin_state", int'(bus.state), 0);
    chk("cspin_motor", int'(bus.motor_spin), 0);
    chk("cspin_drain", int'(bus.drain_valve), 0);
    chk("cspin_lock", int'(bus.door_lock), 0);
    repeat (3) cycle();
    chk("cspin_no_done", done_cnt, 0);

    // Async reset mid-RINSE
    bus.water_full = 1;
    pulse_start();
    run_until(3, 150, "rinse_wait");
    bus.water_full = 0;
    bus.tick = 0;
    #2 rst = 1'b1;
    #1;
    chk("arst_state", int'(bus.state), 0);
    chk("arst_sec", int'(bus.sec_left), 0);
    chk("arst_motor", int'(bus.motor_wash), 0);
    chk("arst_drain", int'(bus.drain_valve), 0);
    chk("arst_lock", int'(bus.door_lock), 0);
    @(negedge clk);
    rst = 1'b0;
    cycle(); cycle();

    // Tick and water_full coincide on the last FILL second
    begin
      bit hit = 0;
      pulse_start();
      for (int n = 0; n < 80 && !hit; n++) begin
        if (m_phase == 1 && m_sec == 1 && tcnt == 4) begin
          bus.water_full = 1; cycle(); hit = 1;
        end else cycle();
      end
      bus.water_full = 0;
      chk("coinc_reached", int'(hit), 1);
      chk("coinc_state", int'(bus.state), 2);
      chk("coinc_sec", int'(bus.sec_left), 4);
    end
    bus.cancel = 1; cycle(); bus.cancel = 0;

    // Randomized traffic
    rand_tick = 1;
    for (int n = 0; n < 3000; n++) begin
      bus.start      = ($urandom_range(0, 7) == 0);
      bus.cancel     = ($urandom_range(0, 49) == 0);
      bus.water_full = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 29) == 0) bus.lid_closed = ~bus.lid_closed;
      cycle();
    end

    chk_on = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
